// File: rtl/store_addr_queue.sv
// store_addr_queue: circular store address queue of the load/store unit.
// Dispatch allocates one entry per store at the tail. The AGU fills in the
// address and data-ready flags, and the ROB marks entries committed in program
// order. The oldest committed, fully resolved store is issued to memory with a
// valid/ready handshake. Every entry is also exported as a flat bus so the AGU
// address comparator can check load/store ordering.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_alloc_en, i_alloc_tag         allocation request and its ROB tag
//   o_alloc_idx, o_full, o_empty    tail index and occupancy status
//   i_addr_en, i_addr_idx, i_addr   AGU address write
//   i_data_en, i_data_idx           store-data-ready mark
//   i_commit, i_flush               in-order commit, kill all uncommitted
//   o_st_valid, o_st_addr, o_st_tag head store offered to memory
//   i_st_ready                      memory accepts the head store
//   o_entries_saq                   all entries {A,val,addr,V,D,tag}, entry i
//                                   at [(i+1)*DATA_SAQ-1 : i*DATA_SAQ]
module store_addr_queue #(
  parameter int unsigned WIDTH_SAQ  = 2,
  parameter int unsigned WIDTH_ADDR = 32,
  parameter int unsigned WIDTH_TAG  = 4,
  localparam int unsigned SIZE_SAQ  = 1 << WIDTH_SAQ,
  localparam int unsigned DATA_SAQ  = 4 + WIDTH_ADDR + WIDTH_TAG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_alloc_en,
  input  logic [WIDTH_TAG-1:0]         i_alloc_tag,
  output logic [WIDTH_SAQ-1:0]         o_alloc_idx,
  output logic                         o_full,
  output logic                         o_empty,
  input  logic                         i_addr_en,
  input  logic [WIDTH_SAQ-1:0]         i_addr_idx,
  input  logic [WIDTH_ADDR-1:0]        i_addr,
  input  logic                         i_data_en,
  input  logic [WIDTH_SAQ-1:0]         i_data_idx,
  input  logic                         i_commit,
  input  logic                         i_flush,
  output logic                         o_st_valid,
  output logic [WIDTH_ADDR-1:0]        o_st_addr,
  output logic [WIDTH_TAG-1:0]         o_st_tag,
  input  logic                         i_st_ready,
  output logic [DATA_SAQ*SIZE_SAQ-1:0] o_entries_saq
);

  localparam int unsigned PTR_W = WIDTH_SAQ + 1;

  // Per-entry fields: allocated, address valid, address, data valid, committed, tag
  logic                  a_q    [SIZE_SAQ];
  logic                  a_d    [SIZE_SAQ];
  logic                  val_q  [SIZE_SAQ];
  logic                  val_d  [SIZE_SAQ];
  logic [WIDTH_ADDR-1:0] addr_q [SIZE_SAQ];
  logic [WIDTH_ADDR-1:0] addr_d [SIZE_SAQ];
  logic                  v_q    [SIZE_SAQ];
  logic                  v_d    [SIZE_SAQ];
  logic                  dc_q   [SIZE_SAQ];
  logic                  dc_d   [SIZE_SAQ];
  logic [WIDTH_TAG-1:0]  tag_q  [SIZE_SAQ];
  logic [WIDTH_TAG-1:0]  tag_d  [SIZE_SAQ];

  // Pointers carry a wrap bit above the index bits
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] cmt_q,  cmt_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [WIDTH_SAQ-1:0] head_idx;
  logic [WIDTH_SAQ-1:0] cmt_idx;
  logic [WIDTH_SAQ-1:0] tail_idx;
  logic                 deq;

  assign head_idx = head_q[WIDTH_SAQ-1:0];
  assign cmt_idx  = cmt_q[WIDTH_SAQ-1:0];
  assign tail_idx = tail_q[WIDTH_SAQ-1:0];

  // Status and head-store outputs derived from registered state
  assign o_empty     = (head_q == tail_q);
  assign o_full      = (head_idx == tail_idx) && (head_q[WIDTH_SAQ] != tail_q[WIDTH_SAQ]);
  assign o_alloc_idx = tail_idx;
  assign o_st_valid  = !o_empty && a_q[head_idx] && val_q[head_idx] &&
                       v_q[head_idx] && dc_q[head_idx];
  assign o_st_addr   = addr_q[head_idx];
  assign o_st_tag    = tag_q[head_idx];
  assign deq         = o_st_valid && i_st_ready;

  // Flat export of all entries
  always_comb begin
    o_entries_saq = '0;
    for (int i = 0; i < SIZE_SAQ; i++) begin
      o_entries_saq[i*DATA_SAQ +: DATA_SAQ] =
        {a_q[i], val_q[i], addr_q[i], v_q[i], dc_q[i], tag_q[i]};
    end
  end

  // Next-state: flush overrides address/data/commit/allocate; dequeue is applied last
  always_comb begin
    head_d = head_q;
    cmt_d  = cmt_q;
    tail_d = tail_q;
    for (int i = 0; i < SIZE_SAQ; i++) begin
      a_d[i]    = a_q[i];
      val_d[i]  = val_q[i];
      addr_d[i] = addr_q[i];
      v_d[i]    = v_q[i];
      dc_d[i]   = dc_q[i];
      tag_d[i]  = tag_q[i];
    end

    if (i_flush) begin
      for (int i = 0; i < SIZE_SAQ; i++) begin
        if (a_q[i] && !dc_q[i]) begin
          a_d[i]    = 1'b0;
          val_d[i]  = 1'b0;
          addr_d[i] = '0;
          v_d[i]    = 1'b0;
          tag_d[i]  = '0;
        end
      end
      tail_d = cmt_q;
    end else begin
      // Committed entries keep their address; D is checked before this cycle's commit
      if (i_addr_en && a_q[i_addr_idx] && !dc_q[i_addr_idx]) begin
        addr_d[i_addr_idx] = i_addr;
        val_d[i_addr_idx]  = 1'b1;
      end
      if (i_data_en && a_q[i_data_idx]) begin
        v_d[i_data_idx] = 1'b1;
      end
      if (i_commit && (cmt_q != tail_q)) begin
        dc_d[cmt_idx] = 1'b1;
        cmt_d         = cmt_q + PTR_W'(1);
      end
      if (i_alloc_en && !o_full) begin
        a_d[tail_idx]    = 1'b1;
        val_d[tail_idx]  = 1'b0;
        addr_d[tail_idx] = '0;
        v_d[tail_idx]    = 1'b0;
        dc_d[tail_idx]   = 1'b0;
        tag_d[tail_idx]  = i_alloc_tag;
        tail_d           = tail_q + PTR_W'(1);
      end
    end

    if (deq) begin
      a_d[head_idx]    = 1'b0;
      val_d[head_idx]  = 1'b0;
      addr_d[head_idx] = '0;
      v_d[head_idx]    = 1'b0;
      dc_d[head_idx]   = 1'b0;
      tag_d[head_idx]  = '0;
      head_d           = head_q + PTR_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SIZE_SAQ; i++) begin
        a_q[i]    <= 1'b0;
        val_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        v_q[i]    <= 1'b0;
        dc_q[i]   <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      for (int i = 0; i < SIZE_SAQ; i++) begin
        a_q[i]    <= a_d[i];
        val_q[i]  <= val_d[i];
        addr_q[i] <= addr_d[i];
        v_q[i]    <= v_d[i];
        dc_q[i]   <= dc_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_addr_queue.sv
// Testbench for store_addr_queue: directed scenarios with hand-computed
// expectations; issued stores are checked by a scoreboard monitor.
module tb_store_addr_queue;

  localparam int unsigned WS = 2;
  localparam int unsigned WA = 32;
  localparam int unsigned WT = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4 + WA + WT;
  localparam int unsigned BW = DW * N;

  logic          clk;
  logic          rst;
  logic          i_alloc_en;
  logic [WT-1:0] i_alloc_tag;
  logic [WS-1:0] o_alloc_idx;
  logic          o_full;
  logic          o_empty;
  logic          i_addr_en;
  logic [WS-1:0] i_addr_idx;
  logic [WA-1:0] i_addr;
  logic          i_data_en;
  logic [WS-1:0] i_data_idx;
  logic          i_commit;
  logic          i_flush;
  logic          o_st_valid;
  logic [WA-1:0] o_st_addr;
  logic [WT-1:0] o_st_tag;
  logic          i_st_ready;
  logic [BW-1:0] o_entries_saq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WA-1:0] addr;
    logic [WT-1:0] tag;
  } st_exp_t;
  st_exp_t sb_q[$];

  store_addr_queue dut (
    .clk(clk), .rst(rst),
    .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag),
    .o_alloc_idx(o_alloc_idx), .o_full(o_full), .o_empty(o_empty),
    .i_addr_en(i_addr_en), .i_addr_idx(i_addr_idx), .i_addr(i_addr),
    .i_data_en(i_data_en), .i_data_idx(i_data_idx),
    .i_commit(i_commit), .i_flush(i_flush),
    .o_st_valid(o_st_valid), .o_st_addr(o_st_addr), .o_st_tag(o_st_tag),
    .i_st_ready(i_st_ready), .o_entries_saq(o_entries_saq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] mk(input logic a, input logic val, input logic [WA-1:0] ad,
                                       input logic v, input logic d, input logic [WT-1:0] tag);
    return {a, val, ad, v, d, tag};
  endfunction

  function automatic logic [BW-1:0] ents(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    i_alloc_en = 1'b0; i_alloc_tag = '0;
    i_addr_en  = 1'b0; i_addr_idx  = '0; i_addr = '0;
    i_data_en  = 1'b0; i_data_idx  = '0;
    i_commit   = 1'b0; i_flush     = 1'b0; i_st_ready = 1'b0;
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [WT-1:0] tag);
    i_alloc_en = 1'b1; i_alloc_tag = tag;
    step();
  endtask

  // Scoreboard monitor: every accepted store must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && o_st_valid && i_st_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got addr %h tag %h with no store expected", o_st_addr, o_st_tag);
      end else begin
        st_exp_t e;
        e = sb_q.pop_front();
        if (o_st_addr !== e.addr || o_st_tag !== e.tag) begin
          errors++;
          $display("FAIL issue_store: got addr %h tag %h expected addr %h tag %h",
                   o_st_addr, o_st_tag, e.addr, e.tag);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();

    // Reset state
    do_reset();
    chk("rst_empty", BW'(o_empty), BW'(1));
    chk("rst_full", BW'(o_full), BW'(0));
    chk("rst_st_valid", BW'(o_st_valid), BW'(0));
    chk("rst_alloc_idx", BW'(o_alloc_idx), BW'(0));
    chk("rst_st_addr", BW'(o_st_addr), BW'(0));
    chk("rst_st_tag", BW'(o_st_tag), BW'(0));
    chk("rst_entries", o_entries_saq, '0);

    // Fill four entries, then a refused fifth request
    for (int t = 1; t <= 4; t++) begin
      chk("fill_alloc_idx", BW'(o_alloc_idx), BW'(t - 1));
      alloc(WT'(t));
    end
    chk("fill_full", BW'(o_full), BW'(1));
    chk("fill_empty", BW'(o_empty), BW'(0));
    alloc(4'h9);
    chk("fill5_alloc_idx", BW'(o_alloc_idx), BW'(0));
    chk("fill5_full", BW'(o_full), BW'(1));
    chk("fill5_entries", o_entries_saq,
        ents(mk(1,0,0,0,0,1), mk(1,0,0,0,0,2), mk(1,0,0,0,0,3), mk(1,0,0,0,0,4)));

    // Reset while requests are active overrides them
    rst = 1'b1; i_alloc_en = 1'b1; i_alloc_tag = 4'h7; i_commit = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; idle();
    chk("midrst_entries", o_entries_saq, '0);
    chk("midrst_empty", BW'(o_empty), BW'(1));

    // Single store: allocate, address, data, commit, issue
    do_reset();
    alloc(4'h5);
    i_addr_en = 1'b1; i_addr_idx = 2'd0; i_addr = 32'h1000;
    step();
    chk("single_not_valid_yet", BW'(o_st_valid), BW'(0));
    i_data_en = 1'b1; i_data_idx = 2'd0;
    step();
    i_commit = 1'b1;
    sb_q.push_back('{addr: 32'h1000, tag: 4'h5});
    step();
    chk("single_st_valid", BW'(o_st_valid), BW'(1));
    chk("single_st_addr", BW'(o_st_addr), BW'(32'h1000));
    chk("single_st_tag", BW'(o_st_tag), BW'(5));
    i_st_ready = 1'b1;
    step();
    chk("single_entries_cleared", o_entries_saq, '0);
    chk("single_empty", BW'(o_empty), BW'(1));
    chk("single_st_valid_off", BW'(o_st_valid), BW'(0));

    // Fill, issue two, refill with wrapped tail
    do_reset();
    for (int t = 1; t <= 4; t++) alloc(WT'(t));
    i_addr_en = 1'b1; i_addr_idx = 2'd0; i_addr = 32'h100; i_data_en = 1'b1; i_data_idx = 2'd0;
    step();
    i_addr_en = 1'b1; i_addr_idx = 2'd1; i_addr = 32'h200; i_data_en = 1'b1; i_data_idx = 2'd1;
    step();
    sb_q.push_back('{addr: 32'h100, tag: 4'h1});
    sb_q.push_back('{addr: 32'h200, tag: 4'h2});
    i_commit = 1'b1; step();
    i_commit = 1'b1; step();
    i_st_ready = 1'b1; step();
    i_st_ready = 1'b1; step();
    chk("wrap_full_before", BW'(o_full), BW'(0));
    chk("wrap_alloc_idx0", BW'(o_alloc_idx), BW'(0));
    alloc(4'h6);
    chk("wrap_alloc_idx1", BW'(o_alloc_idx), BW'(1));
    alloc(4'h7);
    chk("wrap_full", BW'(o_full), BW'(1));
    chk("wrap_entries", o_entries_saq,
        ents(mk(1,0,0,0,0,6), mk(1,0,0,0,0,7), mk(1,0,0,0,0,3), mk(1,0,0,0,0,4)));

    // Flush kills uncommitted entries; allocation in the flush cycle is refused
    do_reset();
    for (int t = 1; t <= 3; t++) alloc(WT'(t));
    i_commit = 1'b1; step();
    i_flush = 1'b1; i_alloc_en = 1'b1; i_alloc_tag = 4'hC;
    step();
    chk("flush_entries", o_entries_saq, ents(mk(1,0,0,0,1,1), '0, '0, '0));
    chk("flush_alloc_idx", BW'(o_alloc_idx), BW'(1));
    chk("flush_empty", BW'(o_empty), BW'(0));
    chk("flush_st_valid", BW'(o_st_valid), BW'(0));

    // Full queue: dequeue and allocate together; allocation refused
    do_reset();
    for (int t = 1; t <= 4; t++) alloc(WT'(t));
    i_addr_en = 1'b1; i_addr_idx = 2'd0; i_addr = 32'h40; i_data_en = 1'b1; i_data_idx = 2'd0;
    step();
    sb_q.push_back('{addr: 32'h40, tag: 4'h1});
    i_commit = 1'b1; step();
    chk("fulldeq_st_valid", BW'(o_st_valid), BW'(1));
    chk("fulldeq_full_before", BW'(o_full), BW'(1));
    i_st_ready = 1'b1; i_alloc_en = 1'b1; i_alloc_tag = 4'hA;
    step();
    chk("fulldeq_full_after", BW'(o_full), BW'(0));
    chk("fulldeq_alloc_idx", BW'(o_alloc_idx), BW'(0));
    chk("fulldeq_entries", o_entries_saq,
        ents('0, mk(1,0,0,0,0,2), mk(1,0,0,0,0,3), mk(1,0,0,0,0,4)));

    // Address write and commit to the same entry in one cycle
    i_data_en = 1'b1; i_data_idx = 2'd1;
    step();
    i_addr_en = 1'b1; i_addr_idx = 2'd1; i_addr = 32'h80; i_commit = 1'b1;
    sb_q.push_back('{addr: 32'h80, tag: 4'h2});
    step();
    chk("samecyc_st_valid", BW'(o_st_valid), BW'(1));
    chk("samecyc_st_addr", BW'(o_st_addr), BW'(32'h80));
    i_st_ready = 1'b1;
    step();
    chk("samecyc_entries", o_entries_saq,
        ents('0, '0, mk(1,0,0,0,0,3), mk(1,0,0,0,0,4)));

    // Ignored writes: unallocated address/data, commit on empty queue
    do_reset();
    i_addr_en = 1'b1; i_addr_idx = 2'd2; i_addr = 32'hDEAD;
    step();
    chk("unalloc_addr_entries", o_entries_saq, '0);
    i_data_en = 1'b1; i_data_idx = 2'd3;
    step();
    chk("unalloc_data_entries", o_entries_saq, '0);
    i_commit = 1'b1;
    step();
    alloc(4'h1);
    i_commit = 1'b1;
    step();
    chk("empty_commit_ignored", o_entries_saq, ents(mk(1,0,0,0,1,1), '0, '0, '0));
    i_addr_en = 1'b1; i_addr_idx = 2'd0; i_addr = 32'hBEEF;
    step();
    chk("committed_addr_ignored", o_entries_saq, ents(mk(1,0,0,0,1,1), '0, '0, '0));

    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d stores never issued expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
